// File: rtl/spi_write_controller_pkg.sv
// Shared definitions for the SPI slave write path: FSM encoding, default widths and the
// configuration-memory address windows used by the write and read controllers.
package spi_write_controller_pkg;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_RECV = 2'd1,
    WR_DONE = 2'd2
  } wr_state_e;

  localparam int unsigned DATA_WL_DEF = 8;
  localparam int unsigned ADDR_WL_DEF = 5;

  // Write and read windows are disjoint so the two controllers never collide.
  localparam logic [ADDR_WL_DEF-1:0] WR_START_ADDR = 5'd0;
  localparam logic [ADDR_WL_DEF-1:0] WR_LAST_ADDR  = 5'd19;
  localparam logic [ADDR_WL_DEF-1:0] RD_START_ADDR = 5'd20;
  localparam logic [ADDR_WL_DEF-1:0] RD_LAST_ADDR  = 5'd28;

endpackage

// File: rtl/spi_shift_in.sv
// Serial-to-parallel shifter, MSB first, with a bit counter that flags the final bit of a word.
module spi_shift_in
  import spi_write_controller_pkg::*;
#(
  parameter int unsigned DATA_WL = DATA_WL_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic               bit_i,
  output logic               byte_done_o,
  output logic [DATA_WL-1:0] byte_o
);

  localparam int unsigned CntW = $clog2(DATA_WL);
  localparam logic [CntW-1:0] CntMax = CntW'(DATA_WL - 1);

  // Only DATA_WL-1 bits are stored; the final bit is taken straight from the input.
  logic [DATA_WL-2:0] sr_q, sr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  assign byte_o      = {sr_q, bit_i};
  assign byte_done_o = en_i && (cnt_q == CntMax);

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (en_i) begin
      sr_d  = byte_o[DATA_WL-2:0];
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_write_controller.sv
// SPI slave receive path: assembles MOSI bytes and writes them into the configuration memory
// at an auto-incrementing address, pulsing oWr_DONE after the last address of the window.
module spi_write_controller
  import spi_write_controller_pkg::*;
#(
  parameter int unsigned         DATA_WL    = DATA_WL_DEF,
  parameter int unsigned         ADDR_WL    = ADDR_WL_DEF,
  parameter logic [ADDR_WL-1:0]  START_ADDR = WR_START_ADDR,
  parameter logic [ADDR_WL-1:0]  LAST_ADDR  = WR_LAST_ADDR
) (
  input  logic               iCLK,
  input  logic               iRSTn,
  input  logic               iCLR,
  input  logic               iEN,
  input  logic               MOSI,
  output logic               oWr_EN,
  output logic [ADDR_WL-1:0] oWr_ADDR,
  output logic [DATA_WL-1:0] oWr_DATA,
  output logic               oWr_DONE
);

  logic               byte_done;
  logic [DATA_WL-1:0] byte_val;

  wr_state_e          state_q;
  logic               wr_en_q;
  logic [ADDR_WL-1:0] addr_q;
  logic [DATA_WL-1:0] wr_data_q;

  spi_shift_in #(
    .DATA_WL (DATA_WL)
  ) u_shift (
    .clk_i       (iCLK),
    .rst_ni      (iRSTn),
    .clr_i       (iCLR),
    .en_i        (iEN),
    .bit_i       (MOSI),
    .byte_done_o (byte_done),
    .byte_o      (byte_val)
  );

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      state_q   <= WR_IDLE;
      wr_en_q   <= 1'b0;
      addr_q    <= START_ADDR;
      wr_data_q <= '0;
    end else if (iCLR) begin
      state_q   <= WR_IDLE;
      wr_en_q   <= 1'b0;
      addr_q    <= START_ADDR;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= byte_done;
      if (byte_done) begin
        wr_data_q <= byte_val;
      end
      // Address advances as the strobe cycle ends, so it names the target during the strobe.
      if (wr_en_q) begin
        addr_q <= (addr_q == LAST_ADDR) ? START_ADDR : addr_q + ADDR_WL'(1);
      end
      unique case (state_q)
        WR_IDLE: if (iEN) state_q <= WR_RECV;
        WR_RECV: if (wr_en_q && (addr_q == LAST_ADDR)) state_q <= WR_DONE;
        WR_DONE: state_q <= iEN ? WR_RECV : WR_IDLE;
        default: state_q <= WR_IDLE;
      endcase
    end
  end

  assign oWr_EN   = wr_en_q;
  assign oWr_ADDR = addr_q;
  assign oWr_DATA = wr_data_q;
  assign oWr_DONE = (state_q == WR_DONE);

endmodule

// File: doc/spi_write_controller.md
Name: spi_write_controller

Overview:
SPI-slave receive-side controller; mirrors the MISO read path.
- Samples MOSI one bit per enabled clock, MSB first.
- Assembles 8-bit bytes and writes each into the shared configuration memory at an auto-incrementing address.
- Raises a one-cycle done pulse after the last address of the write window is written.
- Sits between the SPI slave front end (which supplies iEN per SCLK bit) and the register/memory write port.

Parameters:
- DATA_WL, 8, byte width and bits per frame word.
- ADDR_WL, 5, memory address width.
- START_ADDR, 5'd0, first write address; the address counter resets/clears to this value.
- LAST_ADDR, 5'd19, final address of the write window; the write here ends the frame.

Ports:
- iCLK  in  1  system clock, rising edge.
- iRSTn  in  1  asynchronous active-low reset.
- iCLR  in  1  synchronous clear; same effect as reset, wins over all other inputs.
- iEN  in  1  bit strobe; MOSI is valid and sampled on this edge.
- MOSI  in  1  serial data in, MSB first.
- oWr_EN  out  1  one-cycle memory write strobe.
- oWr_ADDR  out  ADDR_WL  write address, valid while oWr_EN=1.
- oWr_DATA  out  DATA_WL  assembled byte, registered, held until the next write.
- oWr_DONE  out  1  one-cycle pulse, frame complete.

Behaviour:
- Reset/iCLR values:
  - shift reg=0, bit_cnt=0.
  - oWr_EN=0, oWr_DATA=0, oWr_ADDR=START_ADDR, oWr_DONE=0.
  - state=IDLE.
- Shift path:
  - When iEN=1: sr <= {sr[DATA_WL-2:0], MOSI}; bit_cnt increments mod DATA_WL.
  - When iEN=0: sr and bit_cnt hold, so a byte may be spread over gaps.
- Byte complete: iEN=1 and bit_cnt==DATA_WL-1 at edge N.
  - Edge N: oWr_DATA <= {sr[DATA_WL-2:0], MOSI} and oWr_EN <= 1.
  - oWr_EN is high for exactly the cycle after edge N, then returns to 0.
  - Latency: last bit sampled at edge N, data visible and strobed from N to N+1.
- Address counter:
  - oWr_ADDR shows the target during the oWr_EN cycle.
  - On the edge ending that cycle: addr <= (addr==LAST_ADDR) ? START_ADDR : addr+1.
- Shifting continues during the oWr_EN cycle. A new byte's bits are accepted back-to-back without a gap.
  - Minimum spacing between strobes is DATA_WL cycles, so strobes never overlap.
- FSM, 2-bit encoding:
  - IDLE: waiting for a frame. Goes to RECV on the first iEN=1.
  - RECV: frame in progress. Goes to DONE on the edge where oWr_EN=1 and oWr_ADDR==LAST_ADDR; otherwise stays in RECV.
  - DONE: oWr_DONE=1 for this single cycle. Always goes to IDLE next cycle. If iEN=1 in DONE, the bit is still shifted and counted, and the next state is RECV instead of IDLE.
  - Illegal encoding: goes to IDLE.
- oWr_DONE = (state==DONE), decoded from the registered state, so it is glitch-free.
- iCLR or reset mid-byte:
  - Partial bits are discarded and no write occurs.
  - Address returns to START_ADDR.
  - iCLR asserted together with a byte-complete edge: iCLR wins and oWr_EN stays 0.
- Address arithmetic: ADDR_WL bits, explicit wrap at LAST_ADDR only. START_ADDR must be ≤ LAST_ADDR, which is a parameter constraint checked by a bench assertion.

Decomposition:
- Shared package holds:
  - state encodings: WR_IDLE=2'd0, WR_RECV=2'd1, WR_DONE=2'd2.
  - DATA_WL and ADDR_WL defaults.
  - the write window bounds 0..19, alongside the read window 20..28 so the two windows never overlap.
- One natural sub-module: spi_shift_in, the DATA_WL serial-to-parallel shifter plus bit counter with byte_done output. The FSM and address counter stay in the top module.

Test Plan:
- Reset, then idle with iEN=0 → oWr_EN=0, oWr_DONE=0, oWr_ADDR=0, oWr_DATA=0 for 20 cycles.
- Back-to-back iEN for 8 bits of 0xA5, MSB first → one oWr_EN pulse the cycle after bit 8, with oWr_ADDR=0 and oWr_DATA=0xA5. Next cycle oWr_ADDR=1.
- Continuous iEN for 20 bytes 0x00..0x13 → writes to addr 0..19 with matching data. oWr_DONE pulses exactly once, the cycle after the addr-19 write. oWr_ADDR is then 0 and the state returns to IDLE.
- Byte 0x3C sent with random iEN gaps of 0-5 cycles between bits → a single write of 0x3C at the current address, and no spurious strobes.
- iCLR after 5 bits, then a full 0x81 → no write for the partial byte, then a write of 0x81 at addr 0.
- iCLR on the same cycle as the 8th bit → oWr_EN stays 0, oWr_ADDR=0, bit_cnt=0.
